// File: rtl/rfi_power_readout.sv
// rfi_power_readout: captures one vector of 2**CHANNEL_ADDR statistic words
// into a ping-pong RAM. Each completed vector is streamed out over a
// valid/ready port with a frame tag and a last-word marker. A vector that
// completes while the reader still owns the other bank is dropped and counted.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   din, din_valid    statistic words, channel order 0..N-1, no backpressure
//   wr_rst            realign the write counter to channel 0
//   m_tdata/m_tvalid/m_tready/m_tlast   readout stream, m_tlast on channel N-1
//   m_frame           accepted-frame index of the frame being streamed
//   dropped           saturating count of dropped frames
//   overflow          sticky drop flag
//   overflow_clr      clears overflow and dropped
module rfi_power_readout #(
    parameter int unsigned DIN_WIDTH       = 16,
    parameter int unsigned CHANNEL_ADDR    = 9,
    parameter int unsigned FRAME_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic                       din_valid,
    input  logic                       wr_rst,
    output logic [DIN_WIDTH-1:0]       m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [FRAME_CNT_WIDTH-1:0] m_frame,
    output logic [FRAME_CNT_WIDTH-1:0] dropped,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int unsigned N       = 2 ** CHANNEL_ADDR;
    localparam int unsigned RAM_AW  = CHANNEL_ADDR + 1;
    localparam int unsigned RAM_DEP = 2 * N;
    localparam logic [CHANNEL_ADDR-1:0]    LAST_CHAN = CHANNEL_ADDR'(N - 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] CNT_MAX   = {FRAME_CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DIN_WIDTH-1:0] mem [RAM_DEP];
    logic [DIN_WIDTH-1:0] rd_data;

    // ------------------------------------------------------------------
    // Writer / bank state
    // ------------------------------------------------------------------
    logic [CHANNEL_ADDR-1:0]    wr_addr;
    logic                       w_sel;
    logic [1:0]                 full;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic [FRAME_CNT_WIDTH-1:0] bank_tag [2];

    logic [CHANNEL_ADDR-1:0] wr_chan_c;
    logic                    frame_done_c;
    logic                    other_free_c;
    logic                    accept_c;
    logic                    drop_c;

    // ------------------------------------------------------------------
    // Reader
    // ------------------------------------------------------------------
    state_t                  state, state_n;
    logic                    r_sel;
    logic [CHANNEL_ADDR-1:0] rd_chan;
    logic                    rd_done;
    logic                    rd_pend;
    logic                    rd_last;
    logic                    sk_valid;
    logic [DIN_WIDTH-1:0]    sk_data;
    logic                    sk_last;

    logic                    pop_c;
    logic                    last_hs_c;
    logic [1:0]              occ_c;
    logic                    room_c;
    logic                    claim_c;
    logic                    claim_bank_c;
    logic                    rd_issue_c;
    logic                    rd_bank_c;
    logic [CHANNEL_ADDR-1:0] rd_chan_c;

    // wr_rst realigns to channel 0 and still lets a coincident word land there
    assign wr_chan_c    = wr_rst ? '0 : wr_addr;
    assign frame_done_c = din_valid && (wr_chan_c == LAST_CHAN);

    assign pop_c     = m_tvalid && m_tready;
    assign last_hs_c = pop_c && m_tlast;

    // The reader bank counts as free if its last word is handed off this edge
    assign other_free_c = !full[~w_sel] || (last_hs_c && (r_sel == ~w_sel));
    assign accept_c     = frame_done_c && other_free_c;
    assign drop_c       = frame_done_c && !other_free_c;

    // Words held or in flight: output reg + skid + outstanding RAM read
    assign occ_c        = 2'(m_tvalid) + 2'(sk_valid) + 2'(rd_pend);
    assign room_c       = (occ_c - 2'(pop_c)) < 2'd2;
    assign claim_bank_c = full[0] ? 1'b0 : 1'b1;

    // RAM write port
    always_ff @(posedge clk) begin
        if (din_valid) begin
            mem[RAM_AW'({w_sel, wr_chan_c})] <= din;
        end
    end

    // RAM read port, one cycle latency
    always_ff @(posedge clk) begin
        if (rd_issue_c) begin
            rd_data <= mem[RAM_AW'({rd_bank_c, rd_chan_c})];
        end
    end

    // Write counter, bank ownership, frame tags and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            w_sel       <= 1'b0;
            full        <= 2'b00;
            frame_cnt   <= '0;
            bank_tag[0] <= '0;
            bank_tag[1] <= '0;
            dropped     <= '0;
            overflow    <= 1'b0;
        end else begin
            if (din_valid) begin
                wr_addr <= wr_chan_c + CHANNEL_ADDR'(1);
            end else if (wr_rst) begin
                wr_addr <= '0;
            end

            if (last_hs_c) begin
                full[r_sel] <= 1'b0;
            end
            if (accept_c) begin
                full[w_sel]     <= 1'b1;
                bank_tag[w_sel] <= frame_cnt;
                frame_cnt       <= frame_cnt + FRAME_CNT_WIDTH'(1);
                w_sel           <= ~w_sel;
            end

            // A drop in the same cycle as a clear leaves exactly one drop recorded
            if (drop_c) begin
                overflow <= 1'b1;
                if (overflow_clr) begin
                    dropped <= FRAME_CNT_WIDTH'(1);
                end else if (dropped != CNT_MAX) begin
                    dropped <= dropped + FRAME_CNT_WIDTH'(1);
                end
            end else if (overflow_clr) begin
                overflow <= 1'b0;
                dropped  <= '0;
            end
        end
    end

    // Reader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Reader next-state and read-issue decode
    always_comb begin
        state_n    = state;
        claim_c    = 1'b0;
        rd_issue_c = 1'b0;
        rd_bank_c  = r_sel;
        rd_chan_c  = rd_chan;
        case (state)
            S_IDLE: begin
                if (|full) begin
                    claim_c    = 1'b1;
                    rd_issue_c = 1'b1;
                    rd_bank_c  = claim_bank_c;
                    rd_chan_c  = '0;
                    state_n    = S_PRIME;
                end
            end
            S_PRIME: begin
                rd_issue_c = !rd_done && room_c;
                state_n    = S_STREAM;
            end
            S_STREAM: begin
                rd_issue_c = !rd_done && room_c;
                if (last_hs_c) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Read address tracking, frame tag latch, output register and skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 1'b0;
            rd_chan  <= '0;
            rd_done  <= 1'b0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
            sk_last  <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_frame  <= '0;
        end else begin
            rd_pend <= rd_issue_c;
            rd_last <= rd_issue_c && (rd_chan_c == LAST_CHAN);
            if (rd_issue_c) begin
                rd_chan <= rd_chan_c + CHANNEL_ADDR'(1);
                rd_done <= (rd_chan_c == LAST_CHAN);
            end

            if (claim_c) begin
                r_sel   <= claim_bank_c;
                m_frame <= bank_tag[claim_bank_c];
            end

            if (pop_c) begin
                // Refill the output register, skid first to keep word order
                if (sk_valid) begin
                    m_tdata  <= sk_data;
                    m_tlast  <= sk_last;
                    m_tvalid <= 1'b1;
                    sk_valid <= rd_pend;
                    sk_data  <= rd_data;
                    sk_last  <= rd_last;
                end else if (rd_pend) begin
                    m_tdata  <= rd_data;
                    m_tlast  <= rd_last;
                    m_tvalid <= 1'b1;
                end else begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            end else if (!m_tvalid) begin
                if (rd_pend) begin
                    m_tdata  <= rd_data;
                    m_tlast  <= rd_last;
                    m_tvalid <= 1'b1;
                end
            end else if (rd_pend) begin
                // Output stalled: park the returning read word in the skid
                sk_valid <= 1'b1;
                sk_data  <= rd_data;
                sk_last  <= rd_last;
            end
        end
    end

endmodule

// File: tb/tb_rfi_power_readout.sv
// Bench for rfi_power_readout with N=8: scoreboard of expected readout words,
// a small table of frames for the back-to-back case, and hand sequences for
// latency, drop, realignment and reset corner cases.
module tb_rfi_power_readout;

    localparam int unsigned DW = 16;
    localparam int unsigned CA = 3;
    localparam int unsigned FW = 32;
    localparam int unsigned N  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          wr_rst;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [FW-1:0] m_frame;
    logic [FW-1:0] dropped;
    logic          overflow;
    logic          overflow_clr;

    rfi_power_readout #(
        .DIN_WIDTH      (DW),
        .CHANNEL_ADDR   (CA),
        .FRAME_CNT_WIDTH(FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .wr_rst      (wr_rst),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_frame     (m_frame),
        .dropped     (dropped),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [FW-1:0] frame;
    } exp_t;

    typedef struct {
        logic [DW-1:0] base;
        logic [FW-1:0] frame;
    } vec_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every handshake pops one expected word
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                check("spurious word", 64'(q.size()), 64'd1);
            end else begin
                mon_e = q.pop_front();
                check("m_tdata", 64'(m_tdata), 64'(mon_e.data));
                check("m_tlast", 64'(m_tlast), 64'(mon_e.last));
                check("m_frame", 64'(m_frame), 64'(mon_e.frame));
            end
        end
    end

    // Downstream ready: 0 = hold, 1 = always, 2 = random
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d words outstanding", q.size());
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        din_valid    = v;
        din          = d;
        wr_rst       = r;
        overflow_clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input logic [DW-1:0] base, input logic [FW-1:0] frame);
        exp_t e;
        for (int i = 0; i < int'(N); i++) begin
            e.data  = base + DW'(i);
            e.last  = (i == int'(N) - 1);
            e.frame = frame;
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < int'(N); i++) drive(1'b1, base + DW'(i), 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        drive(1'b0, '0, 1'b0, 1'b0);
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(q.size()), 64'd0);
        idle(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        din_valid    = 1'b0;
        din          = '0;
        wr_rst       = 1'b0;
        overflow_clr = 1'b0;
        q.delete();
        #15;
        rst_n = 1'b1;
        idle(2);
    endtask

    vec_t tbl[4];
    logic found;

    initial begin
        tbl[0] = '{base: 16'h0100, frame: 32'd0};
        tbl[1] = '{base: 16'h0200, frame: 32'd1};
        tbl[2] = '{base: 16'h0300, frame: 32'd2};
        tbl[3] = '{base: 16'h0400, frame: 32'd3};

        rst_n        = 1'b0;
        din          = '0;
        din_valid    = 1'b0;
        wr_rst       = 1'b0;
        overflow_clr = 1'b0;
        #12;
        check("rst m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst m_tlast",  64'(m_tlast),  64'd0);
        check("rst m_tdata",  64'(m_tdata),  64'd0);
        check("rst m_frame",  64'(m_frame),  64'd0);
        check("rst dropped",  64'(dropped),  64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;

        // Single frame, ready high: latency and gap-free burst
        ready_mode = 1;
        idle(2);
        push_frame(16'd10, 32'd0);
        send_frame(16'd10);
        idle(1);
        idle(1);
        check("lat +1 valid low", 64'(m_tvalid), 64'd0);
        idle(1);
        check("lat +2 valid", 64'(m_tvalid), 64'd1);
        check("lat +2 data", 64'(m_tdata), 64'd10);
        for (int k = 1; k < int'(N); k++) begin
            idle(1);
            check("burst valid", 64'(m_tvalid), 64'd1);
        end
        idle(1);
        check("after last valid", 64'(m_tvalid), 64'd0);
        wait_drain("drain single", 100);

        // Back-to-back frames, one word per 4 clk, random ready
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 4; i++) begin
            push_frame(tbl[i].base, tbl[i].frame);
            for (int w = 0; w < int'(N); w++) begin
                drive(1'b1, tbl[i].base + DW'(w), 1'b0, 1'b0);
                idle(3);
            end
        end
        wait_drain("drain table", 500);
        check("table dropped", 64'(dropped), 64'd0);
        check("table overflow", 64'(overflow), 64'd0);

        // Ready held low: first frame held, later frames dropped; drop beats clear
        ready_mode = 0;
        do_reset();
        push_frame(16'h0030, 32'd0);
        send_frame(16'h0030);
        send_frame(16'h0040);
        for (int w = 0; w < int'(N) - 1; w++) drive(1'b1, 16'h0050 + DW'(w), 1'b0, 1'b0);
        drive(1'b1, 16'h0057, 1'b0, 1'b1);
        idle(4);
        check("hold dropped", 64'(dropped), 64'd1);
        check("hold overflow", 64'(overflow), 64'd1);
        check("hold valid", 64'(m_tvalid), 64'd1);
        check("hold data", 64'(m_tdata), 64'h30);
        idle(3);
        check("hold data stable", 64'(m_tdata), 64'h30);
        ready_mode = 1;
        wait_drain("drain held", 100);
        idle(20);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("clr overflow", 64'(overflow), 64'd0);
        check("clr dropped", 64'(dropped), 64'd0);
        push_frame(16'h0060, 32'd1);
        send_frame(16'h0060);
        wait_drain("drain after clr", 100);

        // Frame completes on the same edge as the last-word handshake
        do_reset();
        ready_mode = 1;
        idle(2);
        push_frame(16'h0070, 32'd0);
        push_frame(16'h0080, 32'd1);
        send_frame(16'h0070);
        idle(2);
        send_frame(16'h0080);
        idle(1);
        check("coinc gap0 valid", 64'(m_tvalid), 64'd0);
        check("coinc dropped", 64'(dropped), 64'd0);
        idle(1);
        check("coinc gap1 valid", 64'(m_tvalid), 64'd0);
        idle(1);
        check("coinc next valid", 64'(m_tvalid), 64'd1);
        check("coinc next frame", 64'(m_frame), 64'd1);
        check("coinc next data", 64'(m_tdata), 64'h80);
        wait_drain("drain coinc", 100);
        check("coinc overflow", 64'(overflow), 64'd0);

        // Write realignment, alone and together with a valid word
        do_reset();
        ready_mode = 1;
        idle(2);
        push_frame(16'd20, 32'd0);
        for (int w = 0; w < 5; w++) drive(1'b1, 16'h0005 + DW'(w), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        send_frame(16'd20);
        idle(2);
        push_frame(16'h0030, 32'd1);
        for (int w = 0; w < 3; w++) drive(1'b1, 16'h00E0 + DW'(w), 1'b0, 1'b0);
        drive(1'b1, 16'h0030, 1'b1, 1'b0);
        for (int w = 1; w < int'(N); w++) drive(1'b1, 16'h0030 + DW'(w), 1'b0, 1'b0);
        wait_drain("drain wr_rst", 100);

        // Asynchronous reset in the middle of a frame
        do_reset();
        ready_mode = 1;
        idle(2);
        push_frame(16'h00A0, 32'd0);
        send_frame(16'h00A0);
        idle(1);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (m_tvalid && m_tdata == 16'h00A3) found = 1'b1;
        end
        check("reach word 3", 64'(found), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("mid rst m_tvalid", 64'(m_tvalid), 64'd0);
        check("mid rst m_tlast",  64'(m_tlast),  64'd0);
        check("mid rst m_tdata",  64'(m_tdata),  64'd0);
        check("mid rst m_frame",  64'(m_frame),  64'd0);
        #10;
        rst_n = 1'b1;
        idle(2);
        push_frame(16'h00B0, 32'd0);
        send_frame(16'h00B0);
        wait_drain("drain after rst", 100);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
